// File: rtl/apb_cfg_master.sv
// apb_cfg_master: single-outstanding APB initiator bridging a valid/ready request/response pair onto APB.
//   Clock/reset : HCLK, HRESET (asynchronous, active-high)
//   Request     : req_valid_i, req_ready_o, req_write_i, req_addr_i, req_wdata_i
//   Response    : rsp_valid_o, rsp_ready_i, rsp_rdata_o, rsp_err_o, rsp_timeout_o
//   APB         : PADDR, PWDATA, PWRITE, PSEL, PENABLE, PRDATA, PREADY, PSLVERR
//   Option      : define APB_CFG_MASTER_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES wait cycles
module apb_cfg_master #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_nxt;
    logic accept, timeout, done;
    assign accept = state == IDLE && req_valid_i;
    // ACCESS ends on PREADY; a timeout only applies when PREADY is low, so a late PREADY wins
    assign done = state == ACCESS && (PREADY || timeout);
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        req_ready_o = state == IDLE;
        PSEL        = state == SETUP || state == ACCESS;
        PENABLE     = state == ACCESS;
        rsp_valid_o = state == RESP;
        state_nxt   = accept ? SETUP :
                      state == SETUP ? ACCESS :
                      done ? RESP :
                      (state == RESP && rsp_ready_i) ? IDLE : state;
    end
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            if (accept) begin
                PWRITE <= req_write_i;
                PADDR  <= req_addr_i;
                PWDATA <= req_wdata_i;
            end
            if (done) begin
                rsp_rdata_o <= (PREADY && !PWRITE) ? PRDATA : '0;
                rsp_err_o   <= !PREADY || PSLVERR;
            end
        end
    end
`ifdef APB_CFG_MASTER_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        rsp_timeout_q;
    // wait_cnt counts completed ACCESS cycles without PREADY; the last allowed one trips the timeout
    assign timeout       = state == ACCESS && !PREADY && wait_cnt == 16'(TIMEOUT_CYCLES - 1);
    assign rsp_timeout_o = rsp_timeout_q;
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wait_cnt      <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (accept) wait_cnt <= '0;
            else if (state == ACCESS && !PREADY) wait_cnt <= wait_cnt + 16'd1;
            if (done) rsp_timeout_q <= !PREADY;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES != 0;
    assign timeout            = 1'b0;
    assign rsp_timeout_o      = 1'b0;
`endif
endmodule

// File: tb/tb_apb_cfg_master.sv
// tb_apb_cfg_master: randomized self-checking bench for apb_cfg_master against a cycle-timeline model.
module tb_apb_cfg_master;
    localparam int T = 4;
    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_valid_i, req_ready_o, req_write_i;
    logic [11:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
    logic [31:0] rsp_rdata_o;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    int n_cmp = 0;
    int n_err = 0;

    apb_cfg_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(T)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic slave_noise();
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
    endtask

    // Timeline model: cycle k=1 is SETUP, k=2..1+acc is ACCESS, k>=2+acc is RESP.
    // The slave raises PREADY in ACCESS cycle w+1; with the timeout enabled the
    // ACCESS phase is cut at T cycles when w >= T.
    task automatic run_xfer(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                            input int w, input logic [31:0] rd, input bit se, input int rdly);
        bit to_hit, fin, e_err;
        int acc, k;
        logic [31:0] e_rd;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
        to_hit = w >= T;
`else
        to_hit = 1'b0;
`endif
        acc   = to_hit ? T : w + 1;
        e_rd  = (to_hit || wr) ? 32'h0 : rd;
        e_err = to_hit || se;
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wd;
        rsp_ready_i = 1'b0;
        slave_noise();
        k   = 0;
        fin = 1'b0;
        while (!fin && k < 200) begin
            @(posedge HCLK);
            @(negedge HCLK);
            k++;
            check("psel", PSEL, k <= 1 + acc);
            check("penable", PENABLE, k >= 2 && k <= 1 + acc);
            check("rsp_valid", rsp_valid_o, k >= 2 + acc);
            check("req_ready_busy", req_ready_o, 0);
            if (k <= 1 + acc) begin
                check("paddr", PADDR, addr);
                check("pwrite", PWRITE, wr);
                check("pwdata", PWDATA, wd);
            end else begin
                check("rsp_rdata", rsp_rdata_o, e_rd);
                check("rsp_err", rsp_err_o, e_err);
                check("rsp_timeout", rsp_timeout_o, to_hit);
                if (k - 2 - acc >= rdly) begin
                    rsp_ready_i = 1'b1;
                    fin = 1'b1;
                end
            end
            req_write_i = 1'($urandom);
            req_addr_i  = 12'($urandom);
            req_wdata_i = $urandom;
            if (k >= 2 && k <= 1 + acc) begin
                PREADY  = k == w + 2;
                PSLVERR = (k == w + 2) ? se : 1'($urandom);
                PRDATA  = (k == w + 2) ? rd : $urandom;
            end else slave_noise();
        end
        check("xfer_done", fin, 1);
        @(posedge HCLK);
        @(negedge HCLK);
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b0;
        check("idle_rsp_valid", rsp_valid_o, 0);
        check("idle_req_ready", req_ready_o, 1);
        check("idle_psel", PSEL, 0);
    endtask

    // Starts a read whose slave never answers, holds it n ACCESS cycles, then resets mid-ACCESS.
    task automatic reset_abort(input int n);
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 12'($urandom);
        @(posedge HCLK);
        @(negedge HCLK);
        req_valid_i = 1'b0;
        PREADY = 1'b0;
        for (int k = 2; k <= n + 1; k++) begin
            @(posedge HCLK);
            @(negedge HCLK);
            check("hang_psel", PSEL, 1);
            check("hang_penable", PENABLE, 1);
            check("hang_rsp_valid", rsp_valid_o, 0);
            PREADY = 1'b0;
            PRDATA = $urandom;
        end
        #2 HRESET = 1'b1;
        #1;
        check("arst_psel", PSEL, 0);
        check("arst_penable", PENABLE, 0);
        check("arst_rsp_valid", rsp_valid_o, 0);
        check("arst_paddr", PADDR, 0);
        @(negedge HCLK);
        HRESET = 1'b0;
        #1;
        check("rel_req_ready", req_ready_o, 1);
        check("rel_psel", PSEL, 0);
        repeat (3) begin
            @(negedge HCLK);
            check("post_rst_rsp_valid", rsp_valid_o, 0);
            check("post_rst_psel", PSEL, 0);
        end
    endtask

    initial begin
        HRESET      = 1'b1;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b0;
        PRDATA      = '0;
        PREADY      = 1'b0;
        PSLVERR     = 1'b0;
        repeat (2) @(negedge HCLK);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_rdata", rsp_rdata_o, 0);
        check("rst_rsp_err", rsp_err_o, 0);
        check("rst_rsp_timeout", rsp_timeout_o, 0);
        HRESET = 1'b0;
        #1;
        check("rst_req_ready", req_ready_o, 1);
        run_xfer(1'b0, 12'h000, 32'h0, 2, 32'h00040000, 1'b0, 0);
        run_xfer(1'b1, 12'h004, 32'h1A000080, 0, $urandom, 1'b0, 0);
        run_xfer(1'b0, 12'h0F0, 32'h0, 0, 32'hDEADBEEF, 1'b1, 0);
        run_xfer(1'b0, 12'h010, 32'h0, 1, 32'h12345678, 1'b0, 10);
`ifdef APB_CFG_MASTER_TIMEOUT_EN
        run_xfer(1'b0, 12'h020, 32'h0, T - 1, 32'hCAFEF00D, 1'b0, 0);
        run_xfer(1'b0, 12'h024, 32'h0, T, 32'hCAFEF00D, 1'b0, 1);
        run_xfer(1'b1, 12'h028, 32'h55AA55AA, T + 3, 32'h0, 1'b0, 0);
`endif
        for (int i = 0; i < 40; i++)
            run_xfer(1'($urandom), 12'($urandom), $urandom, int'($urandom_range(0, 6)),
                     $urandom, 1'($urandom), int'($urandom_range(0, 3)));
`ifdef APB_CFG_MASTER_TIMEOUT_EN
        reset_abort(T - 1);
`else
        reset_abort(1000);
`endif
        run_xfer(1'b0, 12'h0FC, 32'h0, 1, 32'h0BADC0DE, 1'b0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
